// File: rtl/uart_rx_flow_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_flow_pkg
// Shared constants for the UART receiver with flow control:
//   - parity mode encodings
//   - receiver FSM state type
//   - bit-period divisor rounding helper
// No ports (package).
// ---------------------------------------------------------------------------
package uart_rx_flow_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_t;

    // Clock cycles per bit, rounded to nearest.
    function automatic int unsigned calc_divisor(input int unsigned clk_hz,
                                                 input int unsigned bps);
        return (clk_hz + bps / 2) / bps;
    endfunction

endpackage

// File: rtl/uart_rx_flow_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO. The head word is presented combinationally
// whenever the FIFO is non-empty (zero while empty).
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   i_push      - write request (dropped when full unless popped same cycle)
//   i_pop       - read request (ignored when empty)
//   i_data      - write word
//   o_data      - head word
//   o_full      - level == DEPTH
//   o_empty     - level == 0
//   o_level     - current occupancy
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_level == '0);
    assign o_full    = (r_level == (AW+1)'(DEPTH));
    assign o_level   = r_level;
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    // A pop frees the slot the full-FIFO push writes into (wr_ptr == rd_ptr).
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_flow.sv
// ---------------------------------------------------------------------------
// uart_rx_flow
// UART receiver (configurable data/parity/stop) feeding a show-ahead FIFO,
// with hysteretic clear-to-send flow control.
// Ports:
//   clk            - system clock
//   reset          - synchronous active-high reset
//   rx             - asynchronous serial input, idles high
//   cts            - 1 = sender must pause
//   data           - FIFO head word
//   data_available - FIFO not empty
//   data_read      - consumer pop strobe
//   fill_level     - FIFO occupancy
//   frame_error    - pulse: low stop bit
//   parity_error   - pulse: parity mismatch
//   overrun        - pulse: received word dropped, FIFO full
// ---------------------------------------------------------------------------
module uart_rx_flow
    import uart_rx_flow_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY_HZ = 108_000_000,
    parameter int unsigned SERIAL_BPS       = 2_000_000,
    parameter int unsigned DATA_BITS        = 8,
    parameter int unsigned PARITY           = 0,
    parameter int unsigned STOP_BITS        = 1,
    parameter int unsigned FIFO_DEPTH       = 16,
    parameter int unsigned HIGH_WATER       = FIFO_DEPTH - 4,
    parameter int unsigned LOW_WATER        = FIFO_DEPTH / 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    output logic                          cts,
    output logic [DATA_BITS-1:0]          data,
    output logic                          data_available,
    input  logic                          data_read,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          frame_error,
    output logic                          parity_error,
    output logic                          overrun
);

    localparam int unsigned DIVISOR = calc_divisor(CLK_FREQUENCY_HZ, SERIAL_BPS);
    localparam int unsigned CNT_W   = $clog2(DIVISOR);
    localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(DIVISOR / 2);
    localparam logic [3:0]       DBITS_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic [LVL_W-1:0] HW_LVL     = LVL_W'(HIGH_WATER);
    localparam logic [LVL_W-1:0] LW_LVL     = LVL_W'(LOW_WATER);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_sync_d;
    rx_state_t            r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [3:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_push;
    logic                 r_frame_error;
    logic                 r_parity_error;
    logic                 r_overrun;
    logic                 r_cts;

    logic                 w_par_exp;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_cts;
    logic [LVL_W-1:0]     w_level;

    assign w_par_exp = (PARITY == PARITY_EVEN) ? ^r_shift : ~^r_shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1        <= 1'b1;
            r_sync2        <= 1'b1;
            r_sync_d       <= 1'b1;
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_bit_idx      <= '0;
            r_shift        <= '0;
            r_push         <= 1'b0;
            r_frame_error  <= 1'b0;
            r_parity_error <= 1'b0;
        end else begin
            r_sync1        <= rx;
            r_sync2        <= r_sync1;
            r_sync_d       <= r_sync2;
            r_push         <= 1'b0;
            r_frame_error  <= 1'b0;
            r_parity_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_sync_d && !r_sync2) begin
                        r_state <= ST_START;
                        r_cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= r_sync2 ? ST_IDLE : ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
                        if (r_bit_idx == DBITS_LAST) begin
                            r_bit_idx <= '0;
                            r_state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (r_sync2 != w_par_exp) begin
                            r_parity_error <= 1'b1;
                            r_state        <= ST_WAIT_IDLE;
                        end else begin
                            r_state <= ST_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (!r_sync2) begin
                            r_frame_error <= 1'b1;
                            r_bit_idx     <= '0;
                            r_state       <= ST_WAIT_IDLE;
                        end else if (r_bit_idx == STOP_LAST) begin
                            // r_shift stays stable until the next frame's
                            // data bits, so it is pushed directly.
                            r_push    <= 1'b1;
                            r_bit_idx <= '0;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (r_sync2) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_pop = data_read & ~w_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
            r_cts     <= 1'b0;
        end else begin
            r_overrun <= r_push & w_full & ~w_pop;
            r_cts     <= w_cts;
        end
    end

    // cts follows fill_level in the same cycle it crosses a threshold;
    // r_cts only remembers the hysteresis state between thresholds.
    always_comb begin
        w_cts = r_cts;
        if (w_level >= HW_LVL) begin
            w_cts = 1'b1;
        end else if (w_level <= LW_LVL) begin
            w_cts = 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_push),
        .i_pop   (data_read),
        .i_data  (r_shift),
        .o_data  (data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign cts            = w_cts;
    assign data_available = ~w_empty;
    assign fill_level     = w_level;
    assign frame_error    = r_frame_error;
    assign parity_error   = r_parity_error;
    assign overrun        = r_overrun;

endmodule

// File: tb/tb_uart_rx_flow.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_flow
// Directed/randomised bench for uart_rx_flow: one default instance and one
// even-parity instance. Expected FIFO contents, occupancy and cts come from
// a queue model with threshold hysteresis.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_flow;

    localparam int BIT   = 54;
    localparam int DEPTH = 16;
    localparam int HW    = 12;
    localparam int LW    = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx, rx_p;
    logic       data_read, data_read_p;
    logic       cts, cts_p;
    logic [7:0] data, data_p;
    logic       data_available, data_available_p;
    logic [4:0] fill_level, fill_level_p;
    logic       frame_error, parity_error, overrun;
    logic       frame_error_p, parity_error_p, overrun_p;

    always #5 clk = ~clk;

    uart_rx_flow dut (
        .clk            (clk),
        .reset          (reset),
        .rx             (rx),
        .cts            (cts),
        .data           (data),
        .data_available (data_available),
        .data_read      (data_read),
        .fill_level     (fill_level),
        .frame_error    (frame_error),
        .parity_error   (parity_error),
        .overrun        (overrun)
    );

    uart_rx_flow #(.PARITY(2)) dut_p (
        .clk            (clk),
        .reset          (reset),
        .rx             (rx_p),
        .cts            (cts_p),
        .data           (data_p),
        .data_available (data_available_p),
        .data_read      (data_read_p),
        .fill_level     (fill_level_p),
        .frame_error    (frame_error_p),
        .parity_error   (parity_error_p),
        .overrun        (overrun_p)
    );

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0;
    int fe_p_cnt = 0, pe_p_cnt = 0, ov_p_cnt = 0;
    time t_start, t_rise;
    bit  seen;

    logic [7:0] q[$];
    bit         m_cts = 1'b0;

    always @(negedge clk) begin
        if (frame_error)    fe_cnt++;
        if (parity_error)   pe_cnt++;
        if (overrun)        ov_cnt++;
        if (frame_error_p)  fe_p_cnt++;
        if (parity_error_p) pe_p_cnt++;
        if (overrun_p)      ov_p_cnt++;
    end

    always @(posedge data_available) t_rise = $time;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_update();
        if (q.size() >= HW)      m_cts = 1'b1;
        else if (q.size() <= LW) m_cts = 1'b0;
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_level"}, fill_level, q.size());
        check({tag, "_cts"}, cts, m_cts);
        check({tag, "_avail"}, data_available, q.size() != 0);
        if (q.size() != 0) check({tag, "_head"}, data, q[0]);
    endtask

    task automatic drive_bit(input bit to_p, input logic v);
        if (to_p) rx_p = v;
        else      rx   = v;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input bit to_p, input logic [7:0] d, input bit with_par,
                              input logic pbit, input logic stopv);
        @(negedge clk);
        t_start = $time;
        drive_bit(to_p, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(to_p, d[i]);
        if (with_par) drive_bit(to_p, pbit);
        drive_bit(to_p, stopv);
        if (!stopv) drive_bit(to_p, 1'b1);
    endtask

    task automatic send_good(input logic [7:0] d);
        send_frame(1'b0, d, 1'b0, 1'b0, 1'b1);
        q.push_back(d);
        m_update();
        repeat ($urandom_range(0, 30)) @(negedge clk);
    endtask

    task automatic pop_one();
        @(negedge clk);
        data_read = 1'b1;
        @(negedge clk);
        data_read = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        m_update();
    endtask

    initial begin
        logic [7:0] b;
        reset = 1'b1; rx = 1'b1; rx_p = 1'b1;
        data_read = 1'b0; data_read_p = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_cts", cts, 0);
        check("rst_avail", data_available, 0);
        check("rst_level", fill_level, 0);
        check("rst_data", data, 0);
        check("rst_errs", {frame_error, parity_error, overrun}, 0);

        // Test 1: 0x41 with latency bound
        t_rise = 0;
        send_good(8'h41);
        check("t1_latency_ok", (t_rise > t_start) && ((t_rise - t_start) <= (54*10+3)*10), 1);
        check_state("t1");
        check("t1_no_err", fe_cnt + pe_cnt + ov_cnt, 0);
        pop_one();
        check_state("t1_pop");

        // Pop while empty is ignored
        pop_one();
        check_state("empty_pop");

        // Test 2: glitch, then a good byte proves the FSM is idle again
        @(negedge clk);
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        check_state("t2_glitch");
        check("t2_no_err", fe_cnt + pe_cnt + ov_cnt, 0);
        b = 8'($urandom);
        send_good(b);
        check_state("t2_after");
        pop_one();

        // Reset mid-frame abandons the frame silently
        @(negedge clk);
        rx = 1'b0;
        repeat (200) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rx = 1'b1;
        repeat (600) @(negedge clk);
        check_state("rst_mid");
        check("rst_mid_no_err", fe_cnt + pe_cnt + ov_cnt, 0);

        // Test 3: framing error then good 0xAA
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("t3_fe_count", fe_cnt, 1);
        check_state("t3_bad");
        send_good(8'hAA);
        check_state("t3_good");
        check("t3_fe_once", fe_cnt, 1);
        pop_one();

        // Test 4: even parity instance
        send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check("t4_pe_count", pe_p_cnt, 1);
        check("t4_bad_level", fill_level_p, 0);
        send_frame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        check("t4_good_level", fill_level_p, 1);
        check("t4_good_data", data_p, 8'h03);
        check("t4_good_avail", data_available_p, 1);
        check("t4_pe_once", pe_p_cnt, 1);
        check("t4_no_fe_ov", fe_p_cnt + ov_p_cnt, 0);
        check("t4_cts", cts_p, 0);

        // Test 5: flow control hysteresis
        for (int i = 0; i < 12; i++) begin
            send_good(8'($urandom));
            check_state("t5_fill");
        end
        while (q.size() > LW) begin
            pop_one();
            check_state("t5_drain");
        end

        // Test 6: overrun
        while (q.size() < DEPTH) begin
            send_good(8'($urandom));
            check_state("t6_fill");
        end
        send_frame(1'b0, 8'h7E, 1'b0, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        check("t6_ov_count", ov_cnt, 1);
        check_state("t6_drop");

        seen = 1'b0;
        fork
            send_frame(1'b0, 8'h7E, 1'b0, 1'b0, 1'b1);
            begin
                for (int k = 0; k < 800 && !seen; k++) begin
                    @(negedge clk);
                    if (dut.r_push) begin
                        seen = 1'b1;
                        data_read = 1'b1;
                        @(negedge clk);
                        data_read = 1'b0;
                    end
                end
            end
        join
        check("t6_push_seen", seen, 1);
        void'(q.pop_front());
        q.push_back(8'h7E);
        m_update();
        repeat (5) @(negedge clk);
        check("t6_ov_still_one", ov_cnt, 1);
        check_state("t6_accept");

        while (q.size() > 1) begin
            pop_one();
            check_state("t6_drain");
        end
        check("t6_last_7e", data, 8'h7E);
        pop_one();
        check_state("t6_empty");
        check("end_fe_pe", fe_cnt + pe_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
